// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Optional feature macro used by the top: FETCH_SEQ_FLUSH_CNT_EN.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        DRAIN = 2'b11
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam int          JUMP_INDEX_W     = 26;

endpackage

// File: rtl/next_pc_calc.sv
// Redirect target computation for jumps and taken branches.
// Purely combinational; jump has priority over branch.
module next_pc_calc
    import fetch_seq_pkg::*;
(
    input  logic [31:0]             last_pc,
    input  logic                    jump_req,
    input  logic [JUMP_INDEX_W-1:0] jump_index,
    input  logic                    br_req,
    input  logic [31:0]             br_imm,
    output logic [31:0]             target,
    output logic                    redirect
);

    logic [31:0] w_seq;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_br_tgt;

    // Both targets are relative to the sequential successor of the last accepted instruction
    assign w_seq      = last_pc + INSTR_BYTES;
    assign w_jump_tgt = {w_seq[31:28], jump_index, 2'b00};
    assign w_br_tgt   = w_seq + (br_imm << 2'd2);

    // Pick the redirect target, jump winning over a simultaneous branch
    always_comb begin
        target   = w_br_tgt;
        redirect = 1'b0;
        if (jump_req) begin
            target   = w_jump_tgt;
            redirect = 1'b1;
        end else if (br_req) begin
            target   = w_br_tgt;
            redirect = 1'b1;
        end else begin
            target   = w_br_tgt;
            redirect = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// CPU front-end fetch sequencer: owns the fetch PC, runs one instruction
// memory transaction at a time, holds the returned word until decode takes
// it, and squashes in-flight or held words on jump/branch redirects.
// Optional feature: define FETCH_SEQ_FLUSH_CNT_EN to add the flush_cnt
// output counting squashed instructions.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                    CLK,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic                    imem_ack,
    input  logic [31:0]             imem_rdata,
    output logic                    instr_valid,
    output logic [31:0]             instr,
    output logic [ADDR_W-1:0]       instr_pc,
    input  logic                    instr_ready,
    input  logic                    jump_req,
    input  logic [JUMP_INDEX_W-1:0] jump_index,
    input  logic                    br_req,
    input  logic [31:0]             br_imm,
`ifdef FETCH_SEQ_FLUSH_CNT_EN
    output logic [31:0]             flush_cnt,
`endif
    output logic [ADDR_W-1:0]       pc
);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_last_pc;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;

    logic [ADDR_W-1:0] w_target;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_next_fetch;

    next_pc_calc u_next_pc_calc (
        .last_pc    (r_last_pc),
        .jump_req   (jump_req),
        .jump_index (jump_index),
        .br_req     (br_req),
        .br_imm     (br_imm),
        .target     (w_target),
        .redirect   (w_redirect)
    );

    // Address of the next fetch when a new request is launched this cycle
    assign w_next_fetch = w_redirect ? w_target : r_pc;

    // Fetch state machine; all outputs are registered here
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_last_pc  <= '0;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_valid    <= 1'b0;
            r_instr    <= 32'h0000_0000;
            r_instr_pc <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pc    <= w_next_fetch;
                    r_req   <= 1'b1;
                    r_addr  <= w_next_fetch;
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack && w_redirect) begin
                        // Returned word belongs to the squashed path
                        r_pc    <= w_target;
                        r_addr  <= w_target;
                        r_state <= FETCH;
                    end else if (imem_ack) begin
                        r_instr    <= imem_rdata;
                        r_instr_pc <= r_addr;
                        r_valid    <= 1'b1;
                        r_pc       <= r_addr + INSTR_BYTES;
                        r_req      <= 1'b0;
                        r_state    <= HOLD;
                    end else if (w_redirect) begin
                        // Memory still owes us a word; wait it out before refetching
                        r_pc    <= w_target;
                        r_state <= DRAIN;
                    end else begin
                        r_state <= FETCH;
                    end
                end
                HOLD: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_addr  <= w_target;
                        r_state <= FETCH;
                    end else if (instr_ready) begin
                        r_last_pc <= r_instr_pc;
                        r_valid   <= 1'b0;
                        r_req     <= 1'b1;
                        r_addr    <= r_pc;
                        r_state   <= FETCH;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                DRAIN: begin
                    r_pc <= w_next_fetch;
                    if (imem_ack) begin
                        r_addr  <= w_next_fetch;
                        r_state <= FETCH;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign pc          = r_pc;

`ifdef FETCH_SEQ_FLUSH_CNT_EN
    logic        w_squash;
    logic [31:0] r_flush_cnt;

    // One squashed instruction: held word flushed, acked word discarded, or drain completed
    assign w_squash = ((r_state == HOLD)  && w_redirect) ||
                      ((r_state == FETCH) && imem_ack && w_redirect) ||
                      ((r_state == DRAIN) && imem_ack);

    // Free-running squash counter, wraps naturally
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_flush_cnt <= 32'h0000_0000;
        end else if (w_squash) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
        end else begin
            r_flush_cnt <= r_flush_cnt;
        end
    end

    assign flush_cnt = r_flush_cnt;
`endif

endmodule
